// File: rtl/updown_ctrl_if.sv
// Control/feedback bundle between updown_ctrl and whoever drives it and hosts the counter.
// The turns count is present only when UPDOWN_CTRL_TURNCNT_EN is defined.
interface updown_ctrl_if #(parameter int WIDTH = 4);
    logic             start;
    logic             stop;
    logic [1:0]       mode;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] q;
    logic             t;
    logic             M;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             err;
`ifdef UPDOWN_CTRL_TURNCNT_EN
    logic [7:0]       turns;

    modport master (output start, stop, mode, lo, hi, q,
                    input  t, M, busy, done, wrap, err, turns);
    modport slave  (input  start, stop, mode, lo, hi, q,
                    output t, M, busy, done, wrap, err, turns);
`else
    modport master (output start, stop, mode, lo, hi, q,
                    input  t, M, busy, done, wrap, err);
    modport slave  (input  start, stop, mode, lo, hi, q,
                    output t, M, busy, done, wrap, err);
`endif
endinterface

// File: rtl/updown_ctrl.sv
// Start/stop, prescale and turnaround control for a WIDTH-bit up/down toggle counter.
// Optional wrap/turnaround counter enabled by defining UPDOWN_CTRL_TURNCNT_EN.
module updown_ctrl #(
    parameter int WIDTH = 4,
    parameter int DIV   = 1
) (
    input  logic          clk,
    input  logic          reset,
    updown_ctrl_if.slave  bus
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]    LAST = PW'(DIV - 1);
    localparam logic [WIDTH-1:0] ALL1 = '1;

    typedef enum logic [1:0] {IDLE, RUN_UP, RUN_DN} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_presc;
    logic [1:0]       r_mode;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_hi;
    logic             r_M;
    logic             r_busy;
    logic             r_done;
    logic             r_wrap;
    logic             r_err;

    logic w_tick;
    logic w_limit;
    logic w_reject;
    logic w_accept;

    assign w_tick   = (r_presc == LAST);
    assign w_reject = bus.mode[1] && (bus.lo >= bus.hi);
    assign w_accept = (r_state == IDLE) && bus.start && !bus.stop && !w_reject;

    // Only bounce and sweep park at a bound; free-run modes let the counter wrap.
    always_comb begin
        w_limit = 1'b0;
        case (r_mode)
            2'b10:   w_limit = (r_state == RUN_DN) ? (bus.q <= r_lo) : (bus.q >= r_hi);
            2'b11:   w_limit = (bus.q >= r_hi);
            default: w_limit = 1'b0;
        endcase
    end

    assign bus.t    = w_tick & r_busy & ~bus.stop & ~w_limit;
    assign bus.M    = r_M;
    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.wrap = r_wrap;
    assign bus.err  = r_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_presc <= '0;
            r_mode  <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_M     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wrap  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            r_err  <= 1'b0;
            if (bus.stop) begin
                r_state <= IDLE;
                r_presc <= '0;
                r_M     <= 1'b0;
                r_busy  <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (bus.start) begin
                            if (w_reject) begin
                                r_err <= 1'b1;
                            end else begin
                                r_mode  <= bus.mode;
                                r_lo    <= bus.lo;
                                r_hi    <= bus.hi;
                                r_presc <= '0;
                                r_busy  <= 1'b1;
                                r_state <= (bus.mode == 2'b01) ? RUN_DN : RUN_UP;
                                r_M     <= (bus.mode == 2'b01);
                            end
                        end
                    end
                    default: begin
                        r_presc <= w_tick ? '0 : r_presc + PW'(1);
                        if (w_tick) begin
                            case (r_mode)
                                2'b00: if (bus.q == ALL1) r_wrap <= 1'b1;
                                2'b01: if (bus.q == '0)   r_wrap <= 1'b1;
                                2'b10: if (w_limit) begin
                                    // Turnaround tick: no count, direction flips.
                                    r_state <= (r_state == RUN_UP) ? RUN_DN : RUN_UP;
                                    r_M     <= ~r_M;
                                    r_wrap  <= 1'b1;
                                end
                                default: if (w_limit) begin
                                    r_state <= IDLE;
                                    r_busy  <= 1'b0;
                                    r_M     <= 1'b0;
                                    r_done  <= 1'b1;
                                end
                            endcase
                        end
                    end
                endcase
            end
        end
    end

`ifdef UPDOWN_CTRL_TURNCNT_EN
    logic [7:0] r_turns;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_turns <= '0;
        else if (w_accept)
            r_turns <= '0;
        else if (r_wrap && (r_turns != 8'hFF))
            r_turns <= r_turns + 8'd1;
    end

    assign bus.turns = r_turns;
`endif

endmodule

// File: tb/tb_updown_ctrl.sv
// Two controllers (DIV=1 and DIV=3) each driving a modelled 4-bit up/down counter,
// checked every cycle against a behavioural model plus directed literal expectations.
`timescale 1ns/1ps
module tb_updown_ctrl;
    localparam int W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, stop = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] lo = '0, hi = '0;
    logic       ld = 1'b1;
    logic [3:0] ldv = '0;
    logic [3:0] cnt [2];

    int checks = 0;
    int errors = 0;

    updown_ctrl_if #(.WIDTH(W)) u_if0 ();
    updown_ctrl_if #(.WIDTH(W)) u_if1 ();

    assign u_if0.start = start; assign u_if1.start = start;
    assign u_if0.stop  = stop;  assign u_if1.stop  = stop;
    assign u_if0.mode  = mode;  assign u_if1.mode  = mode;
    assign u_if0.lo    = lo;    assign u_if1.lo    = lo;
    assign u_if0.hi    = hi;    assign u_if1.hi    = hi;
    assign u_if0.q     = cnt[0];
    assign u_if1.q     = cnt[1];

    updown_ctrl #(.WIDTH(W), .DIV(1)) dut0 (.clk(clk), .reset(reset), .bus(u_if0.slave));
    updown_ctrl #(.WIDTH(W), .DIV(3)) dut1 (.clk(clk), .reset(reset), .bus(u_if1.slave));

    logic o_t [2], o_M [2], o_busy [2], o_done [2], o_wrap [2], o_err [2];
    assign o_t[0] = u_if0.t;       assign o_t[1] = u_if1.t;
    assign o_M[0] = u_if0.M;       assign o_M[1] = u_if1.M;
    assign o_busy[0] = u_if0.busy; assign o_busy[1] = u_if1.busy;
    assign o_done[0] = u_if0.done; assign o_done[1] = u_if1.done;
    assign o_wrap[0] = u_if0.wrap; assign o_wrap[1] = u_if1.wrap;
    assign o_err[0] = u_if0.err;   assign o_err[1] = u_if1.err;
`ifdef UPDOWN_CTRL_TURNCNT_EN
    logic [7:0] o_turns [2];
    assign o_turns[0] = u_if0.turns; assign o_turns[1] = u_if1.turns;
`endif

    // The counter being controlled: a plain up/down counter with a bench-side load.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (ld) cnt[k] <= ldv;
            else if (o_t[k]) cnt[k] <= o_M[k] ? cnt[k] - 4'd1 : cnt[k] + 4'd1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int div_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Behavioural model: "running", direction, and ticks elapsed since the run began.
    bit m_run [2], m_dir [2], m_done [2], m_wrap [2], m_err [2];
    int m_mode [2], m_lo [2], m_hi [2], m_since [2], m_turns [2];

    function automatic bit at_bound(input int k);
        int qv = int'(cnt[k]);
        if (m_mode[k] == 2) return m_dir[k] ? (qv <= m_lo[k]) : (qv >= m_hi[k]);
        if (m_mode[k] == 3) return qv >= m_hi[k];
        return 1'b0;
    endfunction

    function automatic bit tick_now(input int k);
        return ((m_since[k] + 1) % div_of(k)) == 0;
    endfunction

    always @(negedge clk) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_run[k] = 0; m_dir[k] = 0; m_done[k] = 0; m_wrap[k] = 0; m_err[k] = 0;
                m_mode[k] = 0; m_lo[k] = 0; m_hi[k] = 0; m_since[k] = 0; m_turns[k] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit tk, nd, nw, ne;
                int qv;
                qv = int'(cnt[k]);
                tk = m_run[k] && tick_now(k);
                chk($sformatf("t%0d", k), int'(o_t[k]), int'(tk && !stop && !at_bound(k)));
                chk($sformatf("M%0d", k), int'(o_M[k]), int'(m_dir[k]));
                chk($sformatf("busy%0d", k), int'(o_busy[k]), int'(m_run[k]));
                chk($sformatf("done%0d", k), int'(o_done[k]), int'(m_done[k]));
                chk($sformatf("wrap%0d", k), int'(o_wrap[k]), int'(m_wrap[k]));
                chk($sformatf("err%0d", k), int'(o_err[k]), int'(m_err[k]));
`ifdef UPDOWN_CTRL_TURNCNT_EN
                chk($sformatf("turns%0d", k), int'(o_turns[k]), m_turns[k]);
`endif
                nd = 0; nw = 0; ne = 0;
                if (m_wrap[k] && m_turns[k] < 255) m_turns[k]++;
                if (stop) begin
                    m_run[k] = 0; m_dir[k] = 0; m_since[k] = 0;
                end else if (!m_run[k]) begin
                    if (start) begin
                        if (mode >= 2 && lo >= hi) ne = 1;
                        else begin
                            m_mode[k] = int'(mode); m_lo[k] = int'(lo); m_hi[k] = int'(hi);
                            m_run[k] = 1; m_dir[k] = (mode == 2'b01); m_since[k] = 0;
                            m_turns[k] = 0;
                        end
                    end
                end else begin
                    m_since[k]++;
                    if (tk) begin
                        case (m_mode[k])
                            0: nw = (qv == 15);
                            1: nw = (qv == 0);
                            2: if (at_bound(k)) begin m_dir[k] = !m_dir[k]; nw = 1; end
                            default: if (at_bound(k)) begin m_run[k] = 0; m_dir[k] = 0; nd = 1; end
                        endcase
                    end
                end
                m_done[k] = nd; m_wrap[k] = nw; m_err[k] = ne;
            end
        end
    end

    task automatic edge1();
        @(posedge clk); #1;
    endtask

    task automatic do_stop();
        edge1(); stop = 1'b1;
        edge1(); stop = 1'b0;
    endtask

    task automatic launch(input logic [1:0] md, input logic [3:0] l, input logic [3:0] h,
                          input logic [3:0] q0);
        mode = md; lo = l; hi = h; ldv = q0; ld = 1'b1; start = 1'b1;
        edge1();
        start = 1'b0; ld = 1'b0;
    endtask

    int exp_q3 [10] = '{3, 4, 5, 6, 6, 5, 4, 3, 3, 4};
    int exp_t3 [10] = '{1, 1, 1, 0, 1, 1, 1, 0, 1, 1};
    int exp_m3 [10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};

    initial begin
        int nt, bad;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; ld = 1'b0;

        // Async reset mid-run.
        launch(2'b10, 4'd3, 4'd8, 4'd5);
        @(negedge clk);
        chk("pre_reset_busy", int'(o_busy[0]), 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_t", int'(o_t[0]), 0);
        chk("rst_M", int'(o_M[0]), 0);
        chk("rst_busy", int'(o_busy[0] | o_busy[1]), 0);
        chk("rst_pulses", int'(o_done[0] | o_wrap[0] | o_err[0]), 0);
        @(negedge clk);
        edge1(); reset = 1'b1;

        // Free-run up through a wrap.
        launch(2'b00, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            chk("up_q", int'(cnt[0]), i % 16);
            chk("up_t", int'(o_t[0]), 1);
            chk("up_wrap", int'(o_wrap[0]), (i == 16) ? 1 : 0);
        end
        do_stop();

        // Bounce between 3 and 6.
        launch(2'b10, 4'd3, 4'd6, 4'd3);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bnc_q", int'(cnt[0]), exp_q3[i]);
            chk("bnc_t", int'(o_t[0]), exp_t3[i]);
            chk("bnc_M", int'(o_M[0]), exp_m3[i]);
            chk("bnc_wrap", int'(o_wrap[0]), (i == 4 || i == 8) ? 1 : 0);
        end
        do_stop();
        @(negedge clk);
`ifdef UPDOWN_CTRL_TURNCNT_EN
        chk("bnc_turns", int'(o_turns[0]), 2);
`endif

        // Sweep 0..9 on the DIV=3 instance.
        launch(2'b11, 4'd0, 4'd9, 4'd0);
        nt = 0; bad = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            nt += int'(o_t[1]);
            if (i < 29 && int'(o_t[1]) != ((i % 3 == 2) ? 1 : 0)) bad++;
            if (i == 27) chk("swp_q27", int'(cnt[1]), 9);
            if (i == 29) begin
                chk("swp_t_last", int'(o_t[1]), 0);
                chk("swp_busy29", int'(o_busy[1]), 1);
            end
            if (i == 30) begin
                chk("swp_done", int'(o_done[1]), 1);
                chk("swp_busy", int'(o_busy[1]), 0);
            end
            if (i == 31) begin
                chk("swp_done_off", int'(o_done[1]), 0);
                chk("swp_hold", int'(cnt[1]), 9);
            end
        end
        chk("swp_ticks", nt, 9);
        chk("swp_phase", bad, 0);

        // Rejected start, then start with stop.
        launch(2'b10, 4'd7, 4'd7, 4'd2);
        @(negedge clk);
        chk("rej_err", int'(o_err[0]), 1);
        chk("rej_busy", int'(o_busy[0]), 0);
        chk("rej_t", int'(o_t[0]), 0);
        @(negedge clk);
        chk("rej_err_off", int'(o_err[0]), 0);
        edge1();
        mode = 2'b00; lo = 4'd0; hi = 4'd5; start = 1'b1; stop = 1'b1;
        edge1();
        start = 1'b0; stop = 1'b0;
        @(negedge clk);
        chk("ss_busy", int'(o_busy[0]), 0);
        chk("ss_err", int'(o_err[0]), 0);

        // Stop during a down run at q=4.
        launch(2'b01, 4'd0, 4'd0, 4'd4);
        stop = 1'b1;
        @(negedge clk);
        chk("stp_t", int'(o_t[0]), 0);
        chk("stp_M_run", int'(o_M[0]), 1);
        chk("stp_q", int'(cnt[0]), 4);
        edge1(); stop = 1'b0;
        @(negedge clk);
        chk("stp_busy", int'(o_busy[0]), 0);
        chk("stp_M", int'(o_M[0]), 0);
        chk("stp_hold", int'(cnt[0]), 4);

        // Randomized traffic, checked by the model every cycle.
        for (int n = 0; n < 600; n++) begin
            edge1();
            stop  = ($urandom_range(0, 24) == 0);
            start = ($urandom_range(0, 5) == 0);
            mode  = 2'($urandom_range(0, 3));
            lo    = 4'($urandom_range(0, 15));
            hi    = 4'($urandom_range(0, 15));
            ld    = ($urandom_range(0, 19) == 0);
            ldv   = 4'($urandom_range(0, 15));
        end
        edge1();
        start = 1'b0; stop = 1'b0; ld = 1'b0;
        repeat (4) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
